// File: rtl/biss_line_delay_ctrl_pkg.sv
// Shared types and constants for the BiSS-C line-delay calibration controller.
package biss_line_delay_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_REQ,
    ST_WAIT_MA,
    ST_MEASURE,
    ST_RESULT,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_STUCK_LOW = 2'd1;
  localparam logic [1:0] ERR_NO_MA     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/biss_line_delay_ctrl_bit_sync.sv
// Multi-stage synchroniser for an asynchronous single-bit line with configurable reset level.
module biss_line_delay_ctrl_bit_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/biss_line_delay_ctrl.sv
// Measures MA-to-ACK round-trip delay over several frames, averages it and programs the
// SLO sampling delay line tap.
module biss_line_delay_ctrl
  import biss_line_delay_ctrl_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int MEAS_LOG2    = 2,
  parameter int TIMEOUT_CLK  = 255,
  parameter int SYNC_STAGES  = 2,
  parameter int MAX_TAPS     = 64,
  parameter int DEFAULT_TAPS = 0,
  localparam int TAP_W       = clog2(MAX_TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_slo_in,
  input  logic             i_ma_edge,
  output logic             o_meas_req,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [1:0]       o_err_code,
  output logic             o_sat,
  output logic [TAP_W-1:0] o_tap_sel
);

  localparam int ACC_W = CNT_W + MEAS_LOG2;
  localparam int RUN_W = MEAS_LOG2 + 1;
  localparam int RUNS  = 1 << MEAS_LOG2;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_wait;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [RUN_W-1:0]   r_run;
  logic [1:0]         r_err_kind;
  logic               r_done;
  logic               r_error;
  logic [1:0]         r_err_code;
  logic               r_sat;
  logic [TAP_W-1:0]   r_tap_sel;

  logic               w_slo_s;
  logic               w_timeout;
  logic               w_last_run;
  logic               w_accept;
  logic               w_sample;
  logic               w_meas_req;
  logic               w_finish_ok;
  logic               w_finish_err;
  logic [1:0]         w_err_kind;
  logic [CNT_W-1:0]   w_comp;
  logic [CNT_W-1:0]   w_contrib;
  logic [CNT_W-1:0]   w_avg;
  logic               w_clip;
  logic [TAP_W-1:0]   w_tap;

  biss_line_delay_ctrl_bit_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_slo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_slo_in),
    .o_q   (w_slo_s)
  );

  assign w_timeout  = (r_wait == CNT_W'(TIMEOUT_CLK));
  assign w_last_run = (r_run == RUN_W'(RUNS - 1));
  // Raw count includes the synchroniser latency; remove it and floor at zero.
  assign w_comp     = (r_cnt > CNT_W'(SYNC_STAGES)) ? (r_cnt - CNT_W'(SYNC_STAGES)) : '0;
  assign w_contrib  = (r_state == ST_MEASURE) ? w_comp : '0;
  assign w_avg      = r_acc[ACC_W-1:MEAS_LOG2];
  assign w_clip     = (w_avg > CNT_W'(MAX_TAPS - 1));
  assign w_tap      = w_clip ? TAP_W'(MAX_TAPS - 1) : w_avg[TAP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_meas_req   = 1'b0;
    w_finish_ok  = 1'b0;
    w_finish_err = 1'b0;
    w_err_kind   = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_slo_s) begin
          w_state_next = ST_REQ;
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
          w_err_kind   = ERR_STUCK_LOW;
        end
      end
      ST_REQ: begin
        w_meas_req   = 1'b1;
        w_state_next = ST_WAIT_MA;
      end
      ST_WAIT_MA: begin
        if (i_ma_edge) begin
          // ACK already visible at the MA edge: a zero-length measurement.
          if (!w_slo_s) begin
            w_sample     = 1'b1;
            w_state_next = w_last_run ? ST_RESULT : ST_WAIT_IDLE;
          end else begin
            w_state_next = ST_MEASURE;
          end
        end else if (w_timeout) begin
          w_state_next = ST_ERR;
          w_err_kind   = ERR_NO_MA;
        end
      end
      ST_MEASURE: begin
        if (w_timeout) begin
          w_state_next = ST_ERR;
          w_err_kind   = ERR_TIMEOUT;
        end else if (!w_slo_s) begin
          w_sample     = 1'b1;
          w_state_next = w_last_run ? ST_RESULT : ST_WAIT_IDLE;
        end
      end
      ST_RESULT: begin
        w_finish_ok  = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_ERR: begin
        w_finish_err = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait     <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_run      <= '0;
      r_err_kind <= ERR_NONE;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_sat      <= 1'b0;
      r_tap_sel  <= TAP_W'(DEFAULT_TAPS);
    end else begin
      if ((w_state_next != r_state) || (r_state == ST_IDLE)) r_wait <= '0;
      else                                                   r_wait <= r_wait + CNT_W'(1);

      r_done <= w_finish_ok | w_finish_err;

      if (w_accept) begin
        r_error    <= 1'b0;
        r_err_code <= ERR_NONE;
        r_sat      <= 1'b0;
        r_acc      <= '0;
        r_run      <= '0;
      end

      // The MA edge cycle counts as zero, so the count already reads 1 in the next cycle.
      if ((r_state == ST_WAIT_MA) && i_ma_edge) r_cnt <= CNT_W'(1);
      else if (r_state == ST_MEASURE)           r_cnt <= r_cnt + CNT_W'(1);

      if (w_sample) begin
        r_acc <= r_acc + ACC_W'(w_contrib);
        r_run <= r_run + RUN_W'(1);
      end

      if ((w_state_next == ST_ERR) && (r_state != ST_ERR)) r_err_kind <= w_err_kind;

      if (w_finish_ok) begin
        r_tap_sel <= w_tap;
        r_sat     <= w_clip;
      end

      if (w_finish_err) begin
        r_error    <= 1'b1;
        r_err_code <= r_err_kind;
      end
    end
  end

  assign o_meas_req = w_meas_req;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = r_done;
  assign o_error    = r_error;
  assign o_err_code = r_err_code;
  assign o_sat      = r_sat;
  assign o_tap_sel  = r_tap_sel;

endmodule
